// File: rtl/dnd_pkg.sv
// Shared constants and types for the MLP denoiser weight loader.
//   N1, N2, W_K, W_OUT  : datapath shape defaults
//   N1_HALF .. FRAME_BEATS : derived table shapes and per-section beat counts
//   IDX_OW / IDX_IW     : widths of the shared outer/inner index counter
//   wl_state_e          : loader FSM states
package dnd_pkg;

  localparam int unsigned N1    = 98;
  localparam int unsigned N2    = 10;
  localparam int unsigned W_K   = 4;
  localparam int unsigned W_OUT = 16;

  localparam int unsigned N1_HALF      = N1 / 2 + 1;
  localparam int unsigned N1_BEATS     = N2 * N1_HALF;
  localparam int unsigned N2_BEATS     = N2 + 1;
  localparam int unsigned TANH_NIB     = W_OUT / W_K;
  localparam int unsigned TANH_ENTRIES = 2 ** W_K;
  localparam int unsigned TANH_BEATS   = TANH_ENTRIES * TANH_NIB;
  localparam int unsigned FRAME_BEATS  = 2 * N1_BEATS + N2_BEATS + TANH_BEATS + 1;

  // The index counter serves every section, so it is sized for the widest one.
  localparam int unsigned IDX_OUTER_N = (N2 > TANH_ENTRIES) ? N2 : TANH_ENTRIES;
  localparam int unsigned IDX_INNER_A = (N1_HALF > N2_BEATS) ? N1_HALF : N2_BEATS;
  localparam int unsigned IDX_INNER_N = (IDX_INNER_A > TANH_NIB) ? IDX_INNER_A : TANH_NIB;
  localparam int unsigned IDX_OW      = $clog2(IDX_OUTER_N);
  localparam int unsigned IDX_IW      = $clog2(IDX_INNER_N);
  localparam int unsigned N2_AW       = $clog2(N2_BEATS);

  typedef enum logic [2:0] {
    StIdle,
    StMag,
    StPol,
    StN2w,
    StTanh,
    StChk
  } wl_state_e;

endpackage

// File: rtl/dnd_wl_index.sv
// Two-level (outer/inner) beat index counter.
//   clk_i, rst_ni       : clock, async active-low reset
//   clr_i               : synchronous clear to 0/0 (has priority over en_i)
//   en_i                : advance by one beat
//   outer_last_i/inner_last_i : terminal values for the current section
//   outer_o/inner_o     : current index
//   last_o              : index sits on the terminal value
// Advancing from the terminal value wraps to 0/0, ready for the next section.
module dnd_wl_index #(
  parameter int unsigned OuterW = 4,
  parameter int unsigned InnerW = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [OuterW-1:0] outer_last_i,
  input  logic [InnerW-1:0] inner_last_i,
  output logic [OuterW-1:0] outer_o,
  output logic [InnerW-1:0] inner_o,
  output logic              last_o
);

  logic [OuterW-1:0] outer_q, outer_d;
  logic [InnerW-1:0] inner_q, inner_d;
  logic              inner_end;

  assign inner_end = (inner_q == inner_last_i);
  assign last_o    = inner_end && (outer_q == outer_last_i);
  assign outer_o   = outer_q;
  assign inner_o   = inner_q;

  always_comb begin
    outer_d = outer_q;
    inner_d = inner_q;
    if (clr_i) begin
      outer_d = '0;
      inner_d = '0;
    end else if (en_i) begin
      if (inner_end) begin
        inner_d = '0;
        outer_d = (outer_q == outer_last_i) ? '0 : outer_q + OuterW'(1);
      end else begin
        inner_d = inner_q + InnerW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outer_q <= '0;
      inner_q <= '0;
    end else begin
      outer_q <= outer_d;
      inner_q <= inner_d;
    end
  end

endmodule

// File: rtl/dnd_weight_loader.sv
// Runtime loader for the MLP denoiser parameter tables.
//   clk, rstn      : clock, async active-low reset
//   load_start     : pulse; starts a frame, or aborts and restarts one in progress
//   in_data/in_valid/in_ready : W_K-bit beat stream from the host
//   weights_n1_mag/weights_n1_pol : layer-1 tables [neuron][tap]
//   weights_n2     : layer-2 table
//   tanh           : activation LUT
//   tables_valid   : last frame completed with a matching checksum
//   load_busy      : frame in progress
//   chk_err        : last completed frame had a checksum mismatch
// Frame: MAG, POL, N2W, TANH sections followed by one XOR checksum beat.
module dnd_weight_loader
  import dnd_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 load_start,
  input  logic [W_K-1:0]                       in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [N2-1:0][N1_HALF-1:0][W_K-1:0]  weights_n1_mag,
  output logic [N2-1:0][N1_HALF-1:0][W_K-1:0]  weights_n1_pol,
  output logic [N2_BEATS-1:0][W_K-1:0]         weights_n2,
  output logic [TANH_ENTRIES-1:0][W_OUT-1:0]   tanh,
  output logic                                 tables_valid,
  output logic                                 load_busy,
  output logic                                 chk_err
);

  wl_state_e state_q, state_d;

  logic [N2-1:0][N1_HALF-1:0][W_K-1:0] mag_q, pol_q;
  logic [N2_BEATS-1:0][W_K-1:0]        n2_q;
  logic [TANH_ENTRIES-1:0][W_OUT-1:0]  tanh_q;
  logic [W_OUT-W_K-1:0]                tanh_sh_q;
  logic [W_OUT-1:0]                    tanh_sh_d;

  logic [W_K-1:0] chk_q, chk_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  logic              beat;
  logic              idx_last;
  logic [IDX_OW-1:0] outer, outer_last;
  logic [IDX_IW-1:0] inner, inner_last;

  assign in_ready = (state_q != StIdle);
  assign load_busy = in_ready;
  // A beat coinciding with load_start belongs to the aborted frame and is dropped.
  assign beat = in_valid && in_ready && !load_start;

  assign weights_n1_mag = mag_q;
  assign weights_n1_pol = pol_q;
  assign weights_n2     = n2_q;
  assign tanh           = tanh_q;
  assign tables_valid   = valid_q;
  assign chk_err        = err_q;

  // Earlier nibbles of a LUT entry collect here, MS nibble first.
  assign tanh_sh_d = {tanh_sh_q, in_data};

  always_comb begin
    outer_last = '0;
    inner_last = '0;
    case (state_q)
      StMag, StPol: begin
        outer_last = IDX_OW'(N2 - 1);
        inner_last = IDX_IW'(N1_HALF - 1);
      end
      StN2w:   inner_last = IDX_IW'(N2_BEATS - 1);
      StTanh: begin
        outer_last = IDX_OW'(TANH_ENTRIES - 1);
        inner_last = IDX_IW'(TANH_NIB - 1);
      end
      default: ;
    endcase
  end

  dnd_wl_index #(
    .OuterW(IDX_OW),
    .InnerW(IDX_IW)
  ) u_index (
    .clk_i       (clk),
    .rst_ni      (rstn),
    .clr_i       (load_start),
    .en_i        (beat),
    .outer_last_i(outer_last),
    .inner_last_i(inner_last),
    .outer_o     (outer),
    .inner_o     (inner),
    .last_o      (idx_last)
  );

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (load_start) begin
      state_d = StMag;
      chk_d   = '0;
      valid_d = 1'b0;
    end else if (beat) begin
      if (state_q == StChk) begin
        valid_d = (in_data == chk_q);
        err_d   = (in_data != chk_q);
      end else begin
        chk_d = chk_q ^ in_data;
      end
      if (idx_last) begin
        case (state_q)
          StMag:   state_d = StPol;
          StPol:   state_d = StN2w;
          StN2w:   state_d = StTanh;
          StTanh:  state_d = StChk;
          StChk:   state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      chk_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mag_q     <= '0;
      pol_q     <= '0;
      n2_q      <= '0;
      tanh_q    <= '0;
      tanh_sh_q <= '0;
    end else if (beat) begin
      case (state_q)
        StMag:  mag_q[outer][inner] <= in_data;
        StPol:  pol_q[outer][inner] <= in_data;
        StN2w:  n2_q[inner[N2_AW-1:0]] <= in_data;
        StTanh: begin
          tanh_sh_q <= tanh_sh_d[W_OUT-W_K-1:0];
          if (inner == IDX_IW'(TANH_NIB - 1)) tanh_q[outer] <= tanh_sh_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dnd_weight_loader.sv
module tb_dnd_weight_loader;
  import dnd_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load_start = 1'b0;
  logic in_valid = 1'b0;
  logic [W_K-1:0] in_data = '0;
  logic in_ready, tables_valid, load_busy, chk_err;
  logic [N2-1:0][N1_HALF-1:0][W_K-1:0] weights_n1_mag, weights_n1_pol;
  logic [N2_BEATS-1:0][W_K-1:0]        weights_n2;
  logic [TANH_ENTRIES-1:0][W_OUT-1:0]  tanh;

  always #5 clk = ~clk;

  dnd_weight_loader dut (
    .clk           (clk),
    .rstn          (rstn),
    .load_start    (load_start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .weights_n1_mag(weights_n1_mag),
    .weights_n1_pol(weights_n1_pol),
    .weights_n2    (weights_n2),
    .tanh          (tanh),
    .tables_valid  (tables_valid),
    .load_busy     (load_busy),
    .chk_err       (chk_err)
  );

  // Behavioural model: a frame is a flat list of beats; position decides the table slot.
  logic [W_K-1:0]   m_mag [N2][N1_HALF];
  logic [W_K-1:0]   m_pol [N2][N1_HALF];
  logic [W_K-1:0]   m_n2  [N2_BEATS];
  logic [W_OUT-1:0] m_tanh[TANH_ENTRIES];
  logic [W_K-1:0]   m_fb  [FRAME_BEATS];
  logic [W_K-1:0]   m_chk;
  bit               m_busy, m_valid, m_err;
  int               m_pos;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  localparam int unsigned POL0  = N1_BEATS;
  localparam int unsigned N2W0  = 2 * N1_BEATS;
  localparam int unsigned TANH0 = 2 * N1_BEATS + N2_BEATS;

  function automatic void report(input string name, input bit ok, input longint act,
                                 input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void m_reset();
    for (int n = 0; n < N2; n++)
      for (int t = 0; t < N1_HALF; t++) begin
        m_mag[n][t] = '0;
        m_pol[n][t] = '0;
      end
    for (int i = 0; i < N2_BEATS; i++) m_n2[i] = '0;
    for (int i = 0; i < TANH_ENTRIES; i++) m_tanh[i] = '0;
    m_busy = 0; m_valid = 0; m_err = 0; m_pos = 0; m_chk = '0;
  endfunction

  function automatic void m_step(input bit ls, input bit v, input logic [W_K-1:0] d);
    int p, off;
    logic [W_OUT-1:0] e;
    if (ls) begin
      m_busy = 1; m_pos = 0; m_chk = '0; m_valid = 0;
    end else if (m_busy && v) begin
      p = m_pos;
      m_fb[p] = d;
      if (p < POL0) m_mag[p / N1_HALF][p % N1_HALF] = d;
      else if (p < N2W0) m_pol[(p - POL0) / N1_HALF][(p - POL0) % N1_HALF] = d;
      else if (p < TANH0) m_n2[p - N2W0] = d;
      else if (p < FRAME_BEATS - 1) begin
        off = p - TANH0;
        if (off % TANH_NIB == TANH_NIB - 1) begin
          e = '0;
          for (int k = 0; k < TANH_NIB; k++) e = (e << W_K) | W_OUT'(m_fb[p - TANH_NIB + 1 + k]);
          m_tanh[off / TANH_NIB] = e;
        end
      end else begin
        m_busy = 0;
        if (d == m_chk) begin m_valid = 1; m_err = 0; end
        else m_err = 1;
      end
      if (p < FRAME_BEATS - 1) m_chk ^= d;
      m_pos++;
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit ok;
    longint a, e;
    if (cmp_en) begin
      report("in_ready", in_ready == m_busy, in_ready, m_busy);
      report("load_busy", load_busy == m_busy, load_busy, m_busy);
      report("tables_valid", tables_valid == m_valid, tables_valid, m_valid);
      report("chk_err", chk_err == m_err, chk_err, m_err);
      ok = 1; a = 0; e = 0;
      for (int n = 0; n < N2; n++)
        for (int t = 0; t < N1_HALF; t++)
          if (ok && weights_n1_mag[n][t] !== m_mag[n][t]) begin
            ok = 0; a = weights_n1_mag[n][t]; e = m_mag[n][t];
          end
      report("mag_table", ok, a, e);
      ok = 1; a = 0; e = 0;
      for (int n = 0; n < N2; n++)
        for (int t = 0; t < N1_HALF; t++)
          if (ok && weights_n1_pol[n][t] !== m_pol[n][t]) begin
            ok = 0; a = weights_n1_pol[n][t]; e = m_pol[n][t];
          end
      report("pol_table", ok, a, e);
      ok = 1; a = 0; e = 0;
      for (int i = 0; i < N2_BEATS; i++)
        if (ok && weights_n2[i] !== m_n2[i]) begin
          ok = 0; a = weights_n2[i]; e = m_n2[i];
        end
      report("n2_table", ok, a, e);
      ok = 1; a = 0; e = 0;
      for (int i = 0; i < TANH_ENTRIES; i++)
        if (ok && tanh[i] !== m_tanh[i]) begin
          ok = 0; a = tanh[i]; e = m_tanh[i];
        end
      report("tanh_table", ok, a, e);
    end
  end

  function automatic logic [W_K-1:0] pat(input int kind, input int i);
    case (kind)
      0:       return W_K'(i % 16);
      1:       return W_K'((i * 7 + 3) % 16);
      default: return W_K'((i * 5 + 9) % 16);
    endcase
  endfunction

  // One clock: inputs held across the edge, model advanced after it.
  task automatic cycle(input bit ls, input bit v, input logic [W_K-1:0] d);
    load_start = ls; in_valid = v; in_data = d;
    @(posedge clk);
    m_step(ls, v, d);
    #1;
    load_start = 0; in_valid = 0;
  endtask

  task automatic drive_beat(input logic [W_K-1:0] d, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) cycle(0, 0, W_K'($urandom));
    cycle(0, 1, d);
  endtask

  task automatic send_frame(input int kind, input bit with_start, input bit corrupt,
                            input int gap_pct, input int stop_at);
    logic [W_K-1:0] x, d;
    x = '0;
    if (with_start) cycle(1, 0, '0);
    for (int i = 0; i < FRAME_BEATS - 1; i++) begin
      if (i == stop_at) return;
      d = pat(kind, i);
      x ^= d;
      drive_beat(d, gap_pct);
    end
    drive_beat(corrupt ? (x ^ W_K'(1)) : x, gap_pct);
  endtask

  // Hand-computed expectations for a clean frame of data[i] = i mod 16.
  task automatic pin_default(input string tag);
    report({tag, "_mag00"}, weights_n1_mag[0][0] == 4'h0, weights_n1_mag[0][0], 4'h0);
    report({tag, "_mag01"}, weights_n1_mag[0][1] == 4'h1, weights_n1_mag[0][1], 4'h1);
    report({tag, "_mag10"}, weights_n1_mag[1][0] == 4'h2, weights_n1_mag[1][0], 4'h2);
    report({tag, "_n2_0"}, weights_n2[0] == 4'h8, weights_n2[0], 4'h8);
    report({tag, "_tanh0"}, tanh[0] == 16'h3456, tanh[0], 16'h3456);
    report({tag, "_valid"}, tables_valid == 1'b1, tables_valid, 1);
    report({tag, "_err"}, chk_err == 1'b0, chk_err, 0);
    report({tag, "_busy"}, load_busy == 1'b0, load_busy, 0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    cmp_en = 1;

    // 1: idle after reset
    repeat (100) cycle(0, 0, '0);
    report("idle_ready", in_ready == 1'b0, in_ready, 0);
    report("idle_valid", tables_valid == 1'b0, tables_valid, 0);

    // 2: clean frame, no gaps; valid exactly one cycle after the checksum beat
    send_frame(0, 1, 0, 0, -1);
    pin_default("clean");

    // 3: corrupted checksum
    send_frame(0, 1, 1, 0, -1);
    report("bad_err", chk_err == 1'b1, chk_err, 1);
    report("bad_valid", tables_valid == 1'b0, tables_valid, 0);
    report("bad_busy", load_busy == 1'b0, load_busy, 0);

    // 4: 30% gaps
    send_frame(0, 1, 0, 30, -1);
    pin_default("gaps");

    // 5: abort after 300 beats; restart coincides with a valid beat that must be dropped
    send_frame(2, 1, 0, 0, 300);
    cycle(1, 1, 4'hA);
    report("abort_mag60", weights_n1_mag[6][0] == 4'hC, weights_n1_mag[6][0], 4'hC);
    send_frame(1, 0, 0, 0, -1);
    report("restart_mag00", weights_n1_mag[0][0] == 4'h3, weights_n1_mag[0][0], 4'h3);
    report("restart_valid", tables_valid == 1'b1, tables_valid, 1);

    // 6: asynchronous reset at beat 600
    send_frame(0, 1, 0, 0, 600);
    rstn = 0;
    m_reset();
    #1;
    report("rst_mag_zero", weights_n1_mag == '0, $countones(weights_n1_mag), 0);
    report("rst_pol_zero", weights_n1_pol == '0, $countones(weights_n1_pol), 0);
    report("rst_n2_zero", weights_n2 == '0, $countones(weights_n2), 0);
    report("rst_tanh_zero", tanh == '0, $countones(tanh), 0);
    report("rst_busy", load_busy == 1'b0, load_busy, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    send_frame(0, 1, 0, 0, -1);
    pin_default("after_rst");

    cycle(0, 0, '0);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnd_weight_loader.md
Name: dnd_weight_loader

Overview:
Runtime programming path for the MLP denoiser's parameter tables. Replaces the hard-wired constant tables. Accepts a W_K-bit valid/ready nibble stream from the host and writes the stream into register arrays with the same shapes the MLP datapath already consumes: layer-1 magnitude/polarity weights, layer-2 weights and the tanh LUT. Closes each frame with an XOR checksum and flags the tables valid only after a clean load.

Parameters:
N1, 98, layer-1 input count (two polarity planes of a 7x7 patch)
N2, 10, hidden neuron count
W_K, 4, weight width and stream beat width
W_OUT, 16, tanh LUT entry width; must be a multiple of W_K

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
load_start  in  1  single-cycle pulse; begins or restarts a frame load
in_data  in  W_K  stream beat
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
weights_n1_mag  out  N2 x (N1/2+1) x W_K  layer-1 magnitude table
weights_n1_pol  out  N2 x (N1/2+1) x W_K  layer-1 polarity table
weights_n2  out  (N2+1) x W_K  layer-2 table
tanh  out  2**W_K x W_OUT  activation LUT
tables_valid  out  1  all tables loaded and checksum passed
load_busy  out  1  frame in progress
chk_err  out  1  sticky: last frame failed its checksum

Behaviour:
- Reset (async, rstn=0): every table entry is 0; tables_valid=0, load_busy=0, chk_err=0, in_ready=0; FSM goes to IDLE.
- FSM states: IDLE, MAG, POL, N2W, TANH, CHK.
  - IDLE -> MAG on load_start.
  - MAG -> POL after N2*(N1/2+1)=500 beats.
  - POL -> N2W after 500 beats.
  - N2W -> TANH after N2+1=11 beats.
  - TANH -> CHK after 2**W_K*W_OUT/W_K=64 beats.
  - CHK -> IDLE after 1 beat.
  - Total frame length at defaults: 1076 beats.
- Stream order: MAG and POL run neuron index outer (0..N2-1) and tap index inner (0..N1/2). N2W runs index 0..N2. TANH runs entry 0..15, 4 nibbles per entry, MS nibble first; the entry register is written when its 4th nibble arrives.
- Each accepted data beat is written into its table element on the accepting clock edge. The output reflects the beat the next cycle.
- in_ready=1 in MAG/POL/N2W/TANH/CHK and 0 in IDLE. No backpressure is applied inside a frame. Gaps with in_valid=0 stall the counters.
- Checksum: running XOR of all data beats, cleared on load_start. The CHK beat must equal the running value.
  - Match: tables_valid=1 and chk_err=0, on the cycle after the CHK beat.
  - Mismatch: chk_err=1 and tables_valid stays 0.
- On load_start: tables_valid=0 and load_busy=1 on the next cycle. load_busy falls on the cycle after the CHK beat.
- Table contents are not cleared on load_start. A partial or failed frame leaves mixed contents, guarded only by tables_valid=0.
- load_start while busy (including in the same cycle as an accepted beat) aborts the frame:
  - That beat is discarded.
  - Counters and checksum clear; FSM goes to MAG.
- Reset mid-frame has the same effect as power-on reset.
- Counter widths are sized with $clog2 of the per-state beat count. The terminal count is compared against constants, not a wrap.

Decomposition:
- Shared package dnd_pkg holds:
  - N1, N2, W_K, W_OUT defaults.
  - Derived constants N1_HALF=N1/2+1, N1_BEATS=N2*N1_HALF, N2_BEATS=N2+1, TANH_NIB=W_OUT/W_K, TANH_BEATS=2**W_K*TANH_NIB, FRAME_BEATS.
  - The loader state enum type.
- One sub-module, dnd_wl_index: a two-level (outer/inner) index counter with enable, clear and a terminal-count flag. It is instantiated once and reconfigured per state via limit inputs.

Test Plan:
1. Reset release, no stimulus -> all outputs 0; in_ready=0; tables_valid=0 for 100 cycles.
2. load_start, then 1076 beats without gaps, with data[i]=i mod 16 and a correct checksum ->
   - weights_n1_mag[0][0]=0, [0][1]=1, [1][0]=50 mod 16=2.
   - weights_n2[0] = beat 1000 value (1000 mod 16 = 8).
   - tanh[0] = beats 1011..1014 = 16'h3456.
   - tables_valid=1 exactly 1 cycle after the CHK beat.
3. Same frame with a corrupted CHK beat (XOR 4'h1) -> chk_err=1, tables_valid=0, load_busy=0.
4. Random in_valid gaps at 30% duty -> contents and final flags identical to scenario 2.
5. load_start pulse after 300 beats, then a full clean frame -> contents match the new frame only; tables_valid=1; no stray write from the aborted beat.
6. rstn asserted at beat 600 -> all tables zero immediately (asynchronous); next load_start loads normally.
